// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch front end.
//
// It issues one 16-bit fetch address per cycle to an instruction memory
// with one cycle of read latency. It presents the returned instruction
// on an IF/ID register. A 1-entry skid buffer catches the response that
// is still in flight when downstream stalls, so no fetch is lost.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   imem_addr    fetch address (always even)
//   imem_data    read data for the address issued one cycle earlier
//   stall        downstream hold; IF/ID frozen while high
//   redirect     flush and refetch from redirect_pc (bit 0 ignored)
//   redirect_pc  redirect target
//   halt         stop fetching until reset (wins over redirect)
//   if_instr     IF/ID instruction
//   if_pc        address of if_instr
//   if_pc_plus2  if_pc + PC_STEP
//   if_valid     IF/ID holds a real instruction
//   halted       unit is in HALT
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2,
   output logic        if_valid,
   output logic        halted
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_pc_q, rsp_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pc_q, skid_pc_d;
   logic        if_valid_q, if_valid_d;
   logic [15:0] if_instr_q, if_instr_d;
   logic [15:0] if_pc_q, if_pc_d;
   logic        issue;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_pc_d     = rsp_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      issue        = 1'b0;

      case (state_q)
         IDLE, RUN: begin
            if (halt) begin
               // pc holds so imem_addr freezes at the last unissued address
               state_d      = HALT;
               rsp_valid_d  = 1'b0;
               skid_valid_d = 1'b0;
               if_valid_d   = 1'b0;
            end else if (redirect) begin
               // redirect overrides stall: everything in flight is wrong-path
               state_d      = RUN;
               pc_d         = redirect_pc & 16'hFFFE;
               rsp_valid_d  = 1'b0;
               skid_valid_d = 1'b0;
               if_valid_d   = 1'b0;
            end else begin
               state_d = RUN;
               // An occupied skid blocks issue even in the release cycle;
               // that cycle drains the skid instead, costing one bubble.
               issue       = (state_q == RUN) && !stall && !skid_valid_q;
               rsp_valid_d = issue;
               if (issue) begin
                  pc_d     = pc_q + PC_STEP;
                  rsp_pc_d = pc_q;
               end
               if (!stall) begin
                  if (skid_valid_q) begin
                     if_valid_d   = 1'b1;
                     if_instr_d   = skid_instr_q;
                     if_pc_d      = skid_pc_q;
                     skid_valid_d = 1'b0;
                  end else if (rsp_valid_q) begin
                     if_valid_d = 1'b1;
                     if_instr_d = imem_data;
                     if_pc_d    = rsp_pc_q;
                  end else begin
                     if_valid_d = 1'b0;
                  end
               end else if (rsp_valid_q) begin
                  // The response arrives whether or not downstream can take it
                  skid_valid_d = 1'b1;
                  skid_instr_d = imem_data;
                  skid_pc_d    = rsp_pc_q;
               end
            end
         end
         HALT: begin
            rsp_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if_valid_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         rsp_valid_q  <= 1'b0;
         rsp_pc_q     <= 16'h0000;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 16'h0000;
         skid_pc_q    <= 16'h0000;
         if_valid_q   <= 1'b0;
         if_instr_q   <= 16'h0000;
         if_pc_q      <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_pc_q     <= rsp_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus2 = if_pc_q + PC_STEP;
   assign if_valid    = if_valid_q;
   assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit against a 1-cycle memory
// returning addr ^ 16'h1111. Outputs are sampled 1 ns after each rising edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] imem_addr;
   logic [15:0] imem_data = 16'h0000;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic [15:0] if_instr, if_pc, if_pc_plus2;
   logic        if_valid, halted;

   int n_chk  = 0;
   int n_pass = 0;

   fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .halt       (halt),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_pc_plus2(if_pc_plus2),
      .if_valid   (if_valid),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // instruction memory: one cycle of read latency
   always @(posedge clk) imem_data <= imem_addr ^ 16'h1111;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic chk_if(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                         input logic [15:0] plus2);
      chk({tag, "_v"}, if_valid, 1'b1);
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_ins"}, if_instr, instr);
      chk({tag, "_p2"}, if_pc_plus2, plus2);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // invariants every cycle out of reset
   always @(negedge clk) begin
      if (rst) begin
         chk("inv_skid_rsp", dut.skid_valid_q && dut.rsp_valid_q, 1'b0);
         chk("inv_addr_lsb", imem_addr[0], 1'b0);
      end
   end

   initial begin
      // reset state
      step(); step();
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_instr", if_instr, 16'h0000);
      chk("rst_pc", if_pc, 16'h0000);
      chk("rst_halted", halted, 1'b0);
      rst = 1'b1;

      // IDLE one cycle, then first issue, then data two cycles later
      step(); chk("idle_addr", imem_addr, 16'h0000); chk("idle_v", if_valid, 1'b0);
      step(); chk("iss0_addr", imem_addr, 16'h0002); chk("iss0_v", if_valid, 1'b0);
      step(); chk_if("seq0", 16'h0000, 16'h1111, 16'h0002);
      step(); chk_if("seq1", 16'h0002, 16'h1113, 16'h0004);
      step(); chk_if("seq2", 16'h0004, 16'h1115, 16'h0006);

      // three stall cycles with 0006 in flight -> skid
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_if("stall", 16'h0004, 16'h1115, 16'h0006);
         chk("stall_addr", imem_addr, 16'h0008);
      end
      stall = 1'b0;
      step(); chk_if("drain", 16'h0006, 16'h1117, 16'h0008);
      step(); chk("bubble_v", if_valid, 1'b0);
      step(); chk_if("resume", 16'h0008, 16'h1119, 16'h000A);

      // redirect during stall, with a skid entry pending
      stall = 1'b1;
      step(); chk_if("stall2", 16'h0008, 16'h1119, 16'h000A);
      redirect = 1'b1; redirect_pc = 16'h0031;
      step(); chk("redir_v", if_valid, 1'b0); chk("redir_addr", imem_addr, 16'h0030);
      redirect = 1'b0; stall = 1'b0;
      step(); chk("redir_bub", if_valid, 1'b0);
      step(); chk_if("redir_tgt", 16'h0030, 16'h1121, 16'h0032);

      // wrap through FFFE -> 0000
      redirect = 1'b1; redirect_pc = 16'hFFFC;
      step(); chk("wrap_v", if_valid, 1'b0); chk("wrap_addr", imem_addr, 16'hFFFC);
      redirect = 1'b0;
      step(); chk("wrap_bub", if_valid, 1'b0);
      step(); chk_if("wrap0", 16'hFFFC, 16'hEEED, 16'hFFFE);
      step(); chk_if("wrap1", 16'hFFFE, 16'hEEEF, 16'h0000);
      step(); chk_if("wrap2", 16'h0000, 16'h1111, 16'h0002);

      // halt wins over simultaneous redirect; later redirect ignored
      halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
      step();
      chk("halt_h", halted, 1'b1); chk("halt_v", if_valid, 1'b0);
      chk("halt_addr", imem_addr, 16'h0004);
      halt = 1'b0;
      step();
      chk("halt2_h", halted, 1'b1); chk("halt2_v", if_valid, 1'b0);
      chk("halt2_addr", imem_addr, 16'h0004);
      redirect = 1'b0;

      // asynchronous reset pulse between edges
      rst = 1'b0;
      #1;
      chk("arst_h", halted, 1'b0); chk("arst_addr", imem_addr, 16'h0000);
      chk("arst_v", if_valid, 1'b0); chk("arst_pc", if_pc, 16'h0000);
      #2 rst = 1'b1;
      step(); chk("re_idle_v", if_valid, 1'b0);
      step(); chk("re_iss_addr", imem_addr, 16'h0002);
      step(); chk_if("re_seq0", 16'h0000, 16'h1111, 16'h0002);
      step(); chk_if("re_seq1", 16'h0002, 16'h1113, 16'h0004);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
